// File: rtl/amm_arb_pkg.sv
// Shared types and constant helpers for the N-to-1 Avalon-MM round-robin arbiter.
package amm_arb_pkg;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits for a single entry.
  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/amm_rsp_fifo.sv
// Owner FIFO: records which port issued each outstanding read, in issue order.
module amm_rsp_fifo
  import amm_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           push_id_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = id_w(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH) + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/amm_nto1_arb_rr.sv
// N-to-1 Avalon-MM arbiter: round-robin grant, lock on stall, in-order read response routing.
module amm_nto1_arb_rr
  import amm_arb_pkg::*;
#(
  parameter int unsigned NUM_M    = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_PEND = 4
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_M*ADDR_W-1:0]       s_address,
  input  logic [NUM_M*(DATA_W/8)-1:0]   s_byteenable,
  input  logic [NUM_M*DATA_W-1:0]       s_writedata,
  input  logic [NUM_M-1:0]              s_read,
  input  logic [NUM_M-1:0]              s_write,
  output logic [NUM_M-1:0]              s_waitrequest,
  output logic [NUM_M*DATA_W-1:0]       s_readdata,
  output logic [NUM_M-1:0]              s_readdatavalid,
  output logic [ADDR_W-1:0]             m_address,
  output logic [DATA_W/8-1:0]           m_byteenable,
  output logic [DATA_W-1:0]             m_writedata,
  output logic                          m_read,
  output logic                          m_write,
  input  logic                          m_waitrequest,
  input  logic [DATA_W-1:0]             m_readdata,
  input  logic                          m_readdatavalid,
  output logic [clog2(MAX_PEND):0]      pend_cnt,
  output logic                          rsp_err
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned ID_W = id_w(NUM_M);

  arb_state_e       state_q;
  logic [ID_W-1:0]  lock_id_q, rr_ptr_q;
  logic             rsp_err_q;

  logic [NUM_M-1:0] elig;
  logic [ID_W-1:0]  win_id, sel_id, next_ptr, head_id;
  logic             win_found, fifo_full, fifo_empty;
  logic             rd_cmd, wr_cmd, accept, rsp_hit;
  int unsigned      cand;

  // Full is the registered FIFO state, so a pop frees a read slot only next cycle.
  assign elig = s_write | (s_read & {NUM_M{~fifo_full}});

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_M;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  assign sel_id   = (state_q == ARB_LOCKED) ? lock_id_q : win_id;
  assign rd_cmd   = ~reset & s_read[sel_id] & ~fifo_full;
  assign wr_cmd   = ~reset & s_write[sel_id];
  assign accept   = (rd_cmd | wr_cmd) & ~m_waitrequest;
  assign next_ptr = (sel_id == ID_W'(NUM_M - 1)) ? '0 : sel_id + ID_W'(1);

  assign m_read       = rd_cmd;
  assign m_write      = wr_cmd;
  assign m_address    = s_address[sel_id*ADDR_W +: ADDR_W];
  assign m_byteenable = s_byteenable[sel_id*BE_W +: BE_W];
  assign m_writedata  = s_writedata[sel_id*DATA_W +: DATA_W];

  always_comb begin
    s_waitrequest = '1;
    if (accept) s_waitrequest[sel_id] = 1'b0;
  end

  assign rsp_hit         = m_readdatavalid & ~reset & ~fifo_empty;
  assign s_readdatavalid = rsp_hit ? (NUM_M'(1) << head_id) : '0;
  assign s_readdata      = {NUM_M{m_readdata}};
  assign rsp_err         = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        state_q  <= ARB_OPEN;
        rr_ptr_q <= next_ptr;
      end else if (rd_cmd | wr_cmd) begin
        state_q   <= ARB_LOCKED;
        lock_id_q <= sel_id;
      end
      if (m_readdatavalid && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

  amm_rsp_fifo #(
    .DEPTH (MAX_PEND),
    .W     (ID_W)
  ) u_owner_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (accept & rd_cmd),
    .push_id_i (sel_id),
    .pop_i     (m_readdatavalid & ~reset),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (pend_cnt)
  );

endmodule
